// File: rtl/ln_arbiter.sv
// Round-robin arbiter that shares one sequential ln core between N_REQ requesters,
// range-checks operands, sequences the start/done handshake and guards it with a watchdog.
module ln_arbiter #(
    parameter int N_REQ   = 4,
    parameter int W       = 10,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ*W-1:0] req_x,
    output logic [N_REQ-1:0]   req_ready,
    output logic [N_REQ-1:0]   rsp_valid,
    output logic [W-1:0]       rsp_y,
    output logic               rsp_err,
    output logic [W-1:0]       ln_x0,
    output logic               ln_start,
    input  logic [W-1:0]       ln_y,
    input  logic               ln_done,
    output logic               busy
);
    localparam int PW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WD_LAST  = WDW'(TIMEOUT - 1);
    localparam logic [PW-1:0]  PTR_INIT = PW'(N_REQ - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [PW-1:0]  ptr_q, ptr_d;
    logic [W-1:0]   x0_q, x0_d;
    logic [W-1:0]   y_q, y_d;
    logic           err_q, err_d;
    logic [WDW-1:0] wd_q, wd_d;

    logic [W-1:0]   req_x_arr [N_REQ];
    logic           gnt_found;
    logic [PW-1:0]  gnt_idx;
    logic [PW-1:0]  cand;
    logic [W-1:0]   gnt_x;
    logic           in_range;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_lane
            assign req_x_arr[gi] = req_x[gi*W +: W];
            assign req_ready[gi] = !rst && (state_q == IDLE) && gnt_found && (gnt_idx == PW'(gi));
            assign rsp_valid[gi] = (state_q == RESP) && (ptr_q == PW'(gi));
        end
    endgenerate

    // Search ptr+1, ptr+2, ... ; descending loop so the nearest candidate wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = PW'((int'(ptr_q) + k) % N_REQ);
            if (req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    assign gnt_x    = req_x_arr[gnt_idx];
    assign in_range = (gnt_x >= W'(128)) && (gnt_x <= W'(255));

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        x0_d    = x0_q;
        y_d     = y_q;
        err_d   = err_q;
        wd_d    = wd_q;
        case (state_q)
            IDLE: begin
                if (gnt_found) begin
                    ptr_d = gnt_idx;
                    if (in_range) begin
                        x0_d    = gnt_x;
                        state_d = START;
                    end else begin
                        y_d     = '0;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            START: begin
                wd_d    = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // done right after start may be left over from the previous operation
                if ((wd_q != '0) && ln_done) begin
                    y_d     = ln_y;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (wd_q == WD_LAST) begin
                    y_d     = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= PTR_INIT;
            x0_q    <= '0;
            y_q     <= '0;
            err_q   <= 1'b0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            x0_q    <= x0_d;
            y_q     <= y_d;
            err_q   <= err_d;
            wd_q    <= wd_d;
        end
    end

    assign ln_x0    = x0_q;
    assign ln_start = (state_q == START);
    assign busy     = (state_q != IDLE);
    assign rsp_y    = y_q;
    assign rsp_err  = err_q;

endmodule

// File: tb/tb_ln_arbiter.sv
// Directed bench for ln_arbiter: vector table of transactions against a small ln core model,
// plus hand-written reset and mid-operation reset sequences.
module tb_ln_arbiter;
    localparam int N = 4;
    localparam int W = 10;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_x = '0;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_y;
    logic           rsp_err;
    logic [W-1:0]   ln_x0;
    logic           ln_start;
    logic [W-1:0]   ln_y = '0;
    logic           ln_done = 1'b0;
    logic           busy;

    int n_cmp = 0;
    int n_bad = 0;

    // core model controls
    logic [W-1:0] core_y = '0;
    int           core_lat = 4;
    bit           core_stale = 1'b0;
    int           cnt = 0;

    ln_arbiter #(.N_REQ(N), .W(W), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_x(req_x), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_y(rsp_y), .rsp_err(rsp_err),
        .ln_x0(ln_x0), .ln_start(ln_start), .ln_y(ln_y), .ln_done(ln_done),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // done rises core_lat cycles after the start cycle; core_lat = 0 means never.
    // In stale mode done stays high through the first WAIT cycle, with junk on ln_y.
    always @(posedge clk) begin
        if (ln_start) begin
            ln_y <= 10'h2AA;
            cnt  <= (core_lat > 0) ? core_lat - 1 : 0;
            if (!core_stale) ln_done <= 1'b0;
        end else if (cnt == 1) begin
            ln_done <= 1'b1;
            ln_y    <= core_y;
            cnt     <= 0;
        end else if (cnt > 1) begin
            cnt     <= cnt - 1;
            ln_done <= 1'b0;
        end
    end

    typedef struct {
        logic [N-1:0]   rv;
        logic [N*W-1:0] x;
        logic [W-1:0]   cy;
        int             clat;
        bit             stale;
        logic [N-1:0]   grant;
        logic [W-1:0]   x0;
        logic [W-1:0]   y;
        bit             err;
        int             starts;
        int             lat;
    } vec_t;

    vec_t tbl [14];

    function automatic vec_t mk(input logic [N-1:0] rv, input logic [N*W-1:0] x,
                                input logic [W-1:0] cy, input int clat, input bit stale,
                                input logic [N-1:0] grant, input logic [W-1:0] x0,
                                input logic [W-1:0] y, input bit err, input int starts,
                                input int lat);
        vec_t v;
        v.rv = rv; v.x = x; v.cy = cy; v.clat = clat; v.stale = stale;
        v.grant = grant; v.x0 = x0; v.y = y; v.err = err; v.starts = starts; v.lat = lat;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Drives one request row, waits for the accept, then for the response, checking both.
    task automatic run_vec(input int id, input vec_t v);
        bit got;
        int lat;
        int starts;
        int start_at;
        logic [N-1:0] rdy;
        req_valid  = v.rv;
        req_x      = v.x;
        core_y     = v.cy;
        core_lat   = v.clat;
        core_stale = v.stale;
        got = 1'b0;
        rdy = '0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                got = 1'b1;
                rdy = req_ready;
            end
        end
        check($sformatf("v%0d req_ready", id), 32'(rdy), 32'(v.grant));
        @(posedge clk); #1;
        req_valid = '0;
        lat = 0; starts = 0; start_at = 0; got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            lat++;
            if (ln_start) begin
                starts++;
                start_at = lat;
                check($sformatf("v%0d ln_x0", id), 32'(ln_x0), 32'(v.x0));
            end
            if (rsp_valid != '0) got = 1'b1;
        end
        check($sformatf("v%0d rsp_seen", id), 32'(got), 32'd1);
        check($sformatf("v%0d rsp_valid", id), 32'(rsp_valid), 32'(v.grant));
        check($sformatf("v%0d rsp_y", id), 32'(rsp_y), 32'(v.y));
        check($sformatf("v%0d rsp_err", id), 32'(rsp_err), 32'(v.err));
        check($sformatf("v%0d latency", id), 32'(lat), 32'(v.lat));
        check($sformatf("v%0d starts", id), 32'(starts), 32'(v.starts));
        if (v.starts == 1) check($sformatf("v%0d start_at", id), 32'(start_at), 32'd1);
        $display("txn %0d: req %b grant %b y %03h err %0b lat %0d", id, v.rv, rsp_valid, rsp_y, rsp_err, lat);
    endtask

    initial begin
        vec_t t1;
        int pulses;

        // ---- reset state ----
        repeat (2) @(negedge clk);
        check("rst req_ready", 32'(req_ready), 32'd0);
        check("rst rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst rsp_y", 32'(rsp_y), 32'd0);
        check("rst rsp_err", 32'(rsp_err), 32'd0);
        check("rst ln_x0", 32'(ln_x0), 32'd0);
        check("rst ln_start", 32'(ln_start), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // ---- basic transaction: x = 0.65, core latency 4 ----
        t1 = mk(4'b0001, {10'h000, 10'h000, 10'h000, 10'h0A6}, 10'h392, 4, 1'b0,
                4'b0001, 10'h0A6, 10'h392, 1'b0, 1, 6);
        run_vec(0, t1);
        @(negedge clk);
        check("t1 busy after", 32'(busy), 32'd0);
        check("t1 rsp_valid after", 32'(rsp_valid), 32'd0);
        check("t1 rsp_y hold", 32'(rsp_y), 32'h392);

        do_reset();

        // ---- vector table (ptr back at N-1) ----
        tbl[0]  = mk(4'b1111, {10'h0C0, 10'h0B0, 10'h0A0, 10'h090}, 10'h3A0, 4, 1'b0, 4'b0001, 10'h090, 10'h3A0, 1'b0, 1, 6);
        tbl[1]  = mk(4'b1111, {10'h0C0, 10'h0B0, 10'h0A0, 10'h090}, 10'h3A1, 4, 1'b0, 4'b0010, 10'h0A0, 10'h3A1, 1'b0, 1, 6);
        tbl[2]  = mk(4'b1111, {10'h0C0, 10'h0B0, 10'h0A0, 10'h090}, 10'h3A2, 4, 1'b0, 4'b0100, 10'h0B0, 10'h3A2, 1'b0, 1, 6);
        tbl[3]  = mk(4'b1111, {10'h0C0, 10'h0B0, 10'h0A0, 10'h090}, 10'h3A3, 4, 1'b0, 4'b1000, 10'h0C0, 10'h3A3, 1'b0, 1, 6);
        tbl[4]  = mk(4'b1111, {10'h0C0, 10'h0B0, 10'h0A0, 10'h090}, 10'h3A4, 4, 1'b0, 4'b0001, 10'h090, 10'h3A4, 1'b0, 1, 6);
        tbl[5]  = mk(4'b0100, {10'h000, 10'h100, 10'h000, 10'h000}, 10'h155, 4, 1'b0, 4'b0100, 10'h000, 10'h000, 1'b1, 0, 1);
        tbl[6]  = mk(4'b0100, {10'h000, 10'h07F, 10'h000, 10'h000}, 10'h155, 4, 1'b0, 4'b0100, 10'h000, 10'h000, 1'b1, 0, 1);
        tbl[7]  = mk(4'b0100, {10'h000, 10'h000, 10'h000, 10'h000}, 10'h155, 4, 1'b0, 4'b0100, 10'h000, 10'h000, 1'b1, 0, 1);
        tbl[8]  = mk(4'b0010, {10'h000, 10'h000, 10'h080, 10'h000}, 10'h3C8, 4, 1'b0, 4'b0010, 10'h080, 10'h3C8, 1'b0, 1, 6);
        tbl[9]  = mk(4'b1000, {10'h0FF, 10'h000, 10'h000, 10'h000}, 10'h3FF, 4, 1'b0, 4'b1000, 10'h0FF, 10'h3FF, 1'b0, 1, 6);
        tbl[10] = mk(4'b1001, {10'h0D0, 10'h000, 10'h000, 10'h0C3}, 10'h211, 4, 1'b0, 4'b0001, 10'h0C3, 10'h211, 1'b0, 1, 6);
        tbl[11] = mk(4'b0001, {10'h000, 10'h000, 10'h000, 10'h0B5}, 10'h2B5, 5, 1'b1, 4'b0001, 10'h0B5, 10'h2B5, 1'b0, 1, 7);
        tbl[12] = mk(4'b0010, {10'h000, 10'h000, 10'h0E0, 10'h000}, 10'h1E0, 0, 1'b0, 4'b0010, 10'h0E0, 10'h000, 1'b1, 1, 17);
        tbl[13] = mk(4'b0100, {10'h000, 10'h0D0, 10'h000, 10'h000}, 10'h1D0, 4, 1'b0, 4'b0100, 10'h0D0, 10'h1D0, 1'b0, 1, 6);

        for (int i = 0; i < 14; i++) run_vec(i + 1, tbl[i]);

        // ---- reset while waiting on a core that never finishes ----
        @(posedge clk); #1;
        req_valid = 4'b0100;
        req_x     = {10'h000, 10'h0C0, 10'h000, 10'h0A6};
        core_lat  = 0;
        core_stale = 1'b0;
        @(negedge clk);
        check("rw req_ready", 32'(req_ready), 32'b0100);
        @(posedge clk); #1;
        req_valid = 4'b0101;
        repeat (3) @(negedge clk);
        check("rw busy before", 32'(busy), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("rw busy", 32'(busy), 32'd0);
        check("rw ln_start", 32'(ln_start), 32'd0);
        check("rw ln_x0", 32'(ln_x0), 32'd0);
        check("rw rsp_valid", 32'(rsp_valid), 32'd0);
        check("rw rsp_y", 32'(rsp_y), 32'd0);
        check("rw rsp_err", 32'(rsp_err), 32'd0);
        check("rw req_ready", 32'(req_ready), 32'd0);
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid != '0) pulses++;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        core_lat = 4;
        core_y   = 10'h0F3;
        @(negedge clk);
        if (rsp_valid != '0) pulses++;
        check("rw no rsp pulse", 32'(pulses), 32'd0);
        check("rw first grant", 32'(req_ready), 32'b0001);
        @(posedge clk); #1;
        req_valid = '0;
        pulses = 0;
        for (int c = 0; c < 40 && pulses == 0; c++) begin
            @(negedge clk);
            if (rsp_valid != '0) pulses = c + 1;
        end
        check("rw after latency", 32'(pulses), 32'd6);
        check("rw after rsp_valid", 32'(rsp_valid), 32'b0001);
        check("rw after rsp_y", 32'(rsp_y), 32'h0F3);
        check("rw after rsp_err", 32'(rsp_err), 32'd0);
        $display("txn rw: grant %b y %03h err %0b", rsp_valid, rsp_y, rsp_err);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, expected finish");
        $fatal(1);
    end

endmodule
